// File: rtl/eth_axis_broadcast.sv
// One-beat registered AXI-Stream broadcaster: copies one packet stream to two sinks
// with an independent valid/ready handshake per sink and frame-boundary enables.
module eth_axis_broadcast #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                en0,
  input  logic                en1,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m0_tvalid,
  output logic                m1_tvalid,
  input  logic                m0_tready,
  input  logic                m1_tready,
  output logic [CNT_W-1:0]    frame_cnt0,
  output logic [CNT_W-1:0]    frame_cnt1,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam int unsigned KEEP_W = DATA_W / 8;

  logic pend0, pend1, in_frame, fen0, fen1;
  logic full, done0, done1, retire;
  logic in_hs, use0, use1, out_hs0, out_hs1;

  // Sink handshake bookkeeping; a sink already served counts as done.
  always_comb begin
    full    = pend0 | pend1;
    done0   = ~pend0 | m0_tready;
    done1   = ~pend1 | m1_tready;
    retire  = done0 & done1;
    in_hs   = s_tvalid & s_tready;
    use0    = in_frame ? fen0 : en0;
    use1    = in_frame ? fen1 : en1;
    out_hs0 = pend0 & m0_tready;
    out_hs1 = pend1 & m1_tready;
  end

  // Combinational path from the sink readies to s_tready is deliberate.
  assign s_tready  = rst_n & (~full | retire);
  assign m0_tvalid = pend0;
  assign m1_tvalid = pend1;

  // Holding register and per-sink pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata <= '0;
      m_tkeep <= KEEP_W'(0);
      m_tlast <= 1'b0;
      pend0   <= 1'b0;
      pend1   <= 1'b0;
    end else if (in_hs) begin
      // Beats with no enabled sink never touch the register.
      if (use0 | use1) begin
        m_tdata <= s_tdata;
        m_tkeep <= s_tkeep;
        m_tlast <= s_tlast;
      end
      pend0 <= use0;
      pend1 <= use1;
    end else begin
      if (out_hs0) pend0 <= 1'b0;
      if (out_hs1) pend1 <= 1'b0;
    end
  end

  // Frame tracking: enables are frozen from the first beat of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame <= 1'b0;
      fen0     <= 1'b0;
      fen1     <= 1'b0;
    end else if (in_hs) begin
      in_frame <= ~s_tlast;
      if (!in_frame) begin
        fen0 <= en0;
        fen1 <= en1;
      end
    end
  end

  // Frame and drop counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      drop_cnt   <= '0;
    end else begin
      if (out_hs0 && m_tlast) frame_cnt0 <= frame_cnt0 + CNT_W'(1);
      if (out_hs1 && m_tlast) frame_cnt1 <= frame_cnt1 + CNT_W'(1);
      if (in_hs && !use0 && !use1 && s_tlast) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/eth_axis_broadcast.md
# eth_axis_broadcast

One-beat registered AXI-Stream broadcaster that copies a single Ethernet packet stream to two independent sinks. Each beat is held until every enabled sink has accepted it. Per-sink enables are sampled at frame boundaries so a sink can be dropped or added without truncating packets. It sits between the UDP packet builder and the two MAC/transmit paths, and replaces the plain AND of the sink tready signals with a correct per-sink valid/ready handshake.

## Interface
- DATA_W, 64: tdata width in bits; tkeep is DATA_W/8 bits.
- CNT_W, 32: width of the frame and drop counters.

- clk  in  1  stream clock; all logic on its rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- s_tdata / s_tkeep / s_tlast  in  DATA_W / DATA_W/8 / 1  input beat.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- en0, en1  in  1  per-sink enable, sampled at frame start.
- m_tdata / m_tkeep / m_tlast  out  DATA_W / DATA_W/8 / 1  registered beat, shared by both sinks.
- m0_tvalid, m1_tvalid  out  1  per-sink valid.
- m0_tready, m1_tready  in  1  per-sink ready.
- frame_cnt0, frame_cnt1  out  CNT_W  count of tlast handshakes completed on each sink; wraps at 2^CNT_W.
- drop_cnt  out  CNT_W  count of frames discarded because both sinks were disabled; wraps.

## Operation
- State: holding register (data, keep, last), pend0, pend1, in_frame, fen0, fen1. full = pend0 | pend1.
- m0_tvalid = pend0 and m1_tvalid = pend1. m_tdata, m_tkeep and m_tlast come from the holding register.
- done_i = ~pend_i | mi_tready. retire = done0 & done1.
- s_tready = rst_n & (~full | retire). The combinational path from mi_tready to s_tready is intended.
- Frame enables:
  - On an input handshake with in_frame=0, the enables used for that beat are en0/en1 from the same cycle; they are latched into fen0/fen1.
  - Enables for later beats of the frame are fen0/fen1.
  - in_frame sets on a non-last handshake and clears on a tlast handshake.
  - Changes to en0/en1 mid-frame are ignored.
- Input handshake: the holding register loads and pend_i <= the enable used for this beat.
  - If both enables are 0, the beat is discarded, full stays 0, and drop_cnt increments on its tlast.
- Output handshake on sink i (pend_i & mi_tready): pend_i clears unless a new beat loads in the same cycle. frame_cnti increments if m_tlast=1.
- The two sinks may accept the same beat in different cycles. A sink that has already accepted the beat must never see it again: pend_i stays 0.
- Single-beat frames (s_tlast on the first beat) set and clear in_frame in the same handshake, so in_frame remains 0.

## Timing
- Reset (rst_n low, asynchronous): pend0, pend1, in_frame, fen0, fen1 and all counters are 0; m0_tvalid = m1_tvalid = 0; s_tready = 0. m_tdata, m_tkeep and m_tlast are 0.
- First cycle after reset release: s_tready = 1.
- Latency: 1 cycle from the input handshake to mi_tvalid.
- Throughput: 1 beat per cycle while every enabled sink holds tready = 1.
- Simultaneous retire and load: the new beat overwrites the register in the same edge with no bubble.
- mi_tvalid must not drop until its handshake completes, except on reset. Data is stable while any pend is set.
- A sink stalled indefinitely stalls the input indefinitely; no timeout.
- Reset mid-frame aborts the frame; no partial counts are kept beyond those already registered.

## Test plan
- Both enabled, both ready, 4-beat frame 0x11..0x44 with tlast on beat 4:
  - each sink sees the 4 beats in consecutive cycles, starting 1 cycle after each input beat.
  - Afterwards frame_cnt0 = frame_cnt1 = 1.
- Skewed ready (m0_tready = 1; m1_tready low for 3 cycles, then high) on a 1-beat frame:
  - m0_tvalid is high for 1 cycle; m1_tvalid is high for 4 cycles; s_tready = 0 until m1 accepts.
  - No duplicate beat on m0.
- en1 = 0 at frame start, raised on beat 2 of a 3-beat frame:
  - m1_tvalid stays 0 for the whole frame; frame_cnt1 stays 0.
  - The next frame reaches m1.
- en0 = en1 = 0 for a 5-beat frame:
  - s_tready = 1 throughout; no mi_tvalid; drop_cnt = 1.
- Reset asserted while pend0 = 1 mid-frame:
  - all valids and counters are 0 immediately; s_tready = 1 on the first cycle after release.
- Counter wrap: preload frame_cnt0 at 2^CNT_W - 1 with CNT_W = 4, then send 1 frame:
  - frame_cnt0 = 0.
